instr_realigner: RTL and testbench
==================================

// Module: instr_realigner
// PURPOSE
//  Fetch-side producer for the compressed decoder. Buffers 32-bit word-aligned fetch
//  words and splits them into instructions: 16-bit (RVC) or 32-bit, including 32-bit
//  instructions that straddle a word boundary. Emits one raw instruction plus PC per
//  handshake. Sits between the fetch/prefetch unit and compressed_decoder.
// PARAMETERS
//  DEPTH     2              word-buffer entries (>=2; 32-bit each)
//  RESET_PC  32'h0000_0000  PC after reset (bit 0 ignored)
// PORTS
//  clk_i                  in   1   clock
//  rst_i                  in   1   reset, asynchronous, active-high
//  fetch_valid_i          in   1   fetch word valid
//  fetch_rdata_i          in   32  fetch word, sequential word-aligned order
//  fetch_ready_o          out  1   buffer can accept a word
//  flush_i                in   1   redirect (branch/jump/trap)
//  flush_addr_i           in   32  redirect target, halfword-aligned
//  instr_valid_o          out  1   instr_o/instr_pc_o valid
//  instr_ready_i          in   1   decoder accepts instruction
//  instr_o                out  32  raw instruction; RVC in [15:0], [31:16]=0
//  instr_pc_o             out  32  PC of instr_o
//  instr_is_compressed_o  out  1   instr_o[1:0] != 2'b11
// BEHAVIOUR
//  State: word buffer (count 0..DEPTH), halfword offset `off` into head word, PC reg.
//  Reset: count=0, off=RESET_PC[1], pc={RESET_PC[31:1],1'b0}; instr_valid_o=0,
//   fetch_ready_o=1 (count==0); holds while rst_i high.
//  fetch_ready_o = (count < DEPTH); purely from state, no comb path from instr_ready_i.
//  Push on fetch_valid_i & fetch_ready_o; word visible at output next cycle (latency 1).
//  Halfwords: h0 = off ? head[31:16] : head[15:0];
//   h1 = off ? word1[15:0] : head[31:16]; h1 present iff (off==0 & count>=1) | (count>=2).
//  instr_valid_o = (count>=1) & (h0[1:0]!=2'b11 | h1 present) & ~flush_i.
//  instr_o = compressed ? {16'h0,h0} : {h1,h0}; instr_pc_o = pc.
//  On instr_valid_o & instr_ready_i (pop):
//   RVC,  off=0 -> off=1, no word pop;   RVC,  off=1 -> off=0, pop 1 word.
//   32b,  off=0 -> pop 1, off=0;         32b,  off=1 -> pop 1, off=1 (straddle).
//   pc += 2 (RVC) or 4 (32b), 32-bit wrap-around, no overflow flag.
//  Push and pop in the same cycle allowed; count = count + push - pop; a full buffer
//   does not accept a push even if a pop occurs that cycle.
//  flush_i (highest priority, synchronous): count=0, off=flush_addr_i[1],
//   pc={flush_addr_i[31:1],1'b0}; a word presented in the flush cycle is dropped;
//   no instruction handshake occurs in the flush cycle. Fetch unit restarts at
//   {flush_addr_i[31:2],2'b00}; the first word after flush is head, upper half used if off=1.
//  Flush with a 32b instruction split pending: partial halfword discarded, no output.
//  Async reset mid-stream: all buffered words discarded immediately.
//  No illegal-instruction detection here; all opcodes forwarded.
// STRUCTURE
//  Package: HALF_W=16, WORD_W=32, typedef fetch_word_t, typedef halfword_t.
//  Sub-module instr_word_fifo (DEPTH x 32, push/pop, peek head and head+1,
//   synchronous clear, count output). Alignment/PC logic in top.
// TESTING
//  1 Reset, words 32'h0013_0513, 32'h0000_4501 -> instrs 32'h0013_0513 @0 (32b),
//    16'h4501 @4 (RVC), off=1 after RVC, pc=6.
//  2 Words 32'h0513_4501, 32'h0000_0013 -> RVC 4501 @0, then straddled
//    32'h0013_0513 @2; next output waits on third word.
//  3 flush_addr_i=32'h0000_0102, word 32'h4505_xxxx -> first output RVC 16'h4505
//    @0x102; lower halfword never emitted.
//  4 instr_ready_i=0, feed DEPTH words -> fetch_ready_o=0; one pop of a 32b instr
//    -> fetch_ready_o=1 next cycle; simultaneous push+pop keeps count constant.
//  5 flush_i asserted with fetch_valid_i=1 and count=DEPTH -> word dropped, count=0,
//    instr_valid_o=0 that cycle and next.
//  6 Assert rst_i mid-stream while instr_valid_o=1 -> instr_valid_o=0 immediately,
//    pc=RESET_PC after release.

Source files
------------

// File: rtl/instr_realigner_pkg.sv
// Shared widths and types for the fetch-side instruction realigner.
package instr_realigner_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] fetch_word_t;
    typedef logic [HALF_W-1:0] halfword_t;

    function automatic logic is_rvc(input halfword_t h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Small circular word buffer exposing the head word and the one behind it.
module instr_word_fifo
    import instr_realigner_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  fetch_word_t                  push_data_i,
    input  logic                         pop_i,
    output fetch_word_t                  head_o,
    output fetch_word_t                  next_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    fetch_word_t      mem_q [DEPTH];
    fetch_word_t      mem_d [DEPTH];
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[ptr_inc(rd_ptr_q)];
    assign count_o = count_q;

endmodule

// File: rtl/instr_realigner.sv
// Splits word-aligned fetch words into 16/32-bit instructions with their PCs.
module instr_realigner
    import instr_realigner_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_is_compressed_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_word_t      head_word;
    fetch_word_t      next_word;
    logic [CNT_W-1:0] count;

    logic        off_q, off_d;
    logic [31:0] pc_q, pc_d;

    halfword_t h0, h1;
    logic      h1_present;
    logic      compressed;
    logic      push, handshake, word_pop;

    instr_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (flush_i),
        .push_i      (push),
        .push_data_i (fetch_rdata_i),
        .pop_i       (word_pop),
        .head_o      (head_word),
        .next_o      (next_word),
        .count_o     (count)
    );

    always_comb begin
        h0         = off_q ? head_word[31:16] : head_word[15:0];
        h1         = off_q ? next_word[15:0]  : head_word[31:16];
        h1_present = (!off_q && count >= CNT_W'(1)) || (count >= CNT_W'(2));
        compressed = is_rvc(h0);

        fetch_ready_o = count < CNT_W'(DEPTH);
        instr_valid_o = (count >= CNT_W'(1)) && (compressed || h1_present) && !flush_i;
        instr_o       = compressed ? {16'h0000, h0} : {h1, h0};
        instr_pc_o    = pc_q;
        instr_is_compressed_o = compressed;

        push      = fetch_valid_i && fetch_ready_o && !flush_i;
        handshake = instr_valid_o && instr_ready_i;
        // An RVC from the lower half leaves the upper half still to be consumed.
        word_pop  = handshake && (!compressed || off_q);
    end

    always_comb begin
        off_d = off_q;
        pc_d  = pc_q;
        if (flush_i) begin
            off_d = flush_addr_i[1];
            pc_d  = {flush_addr_i[31:1], 1'b0};
        end else if (handshake) begin
            off_d = compressed ? !off_q : off_q;
            pc_d  = pc_q + (compressed ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            off_q <= RESET_PC[1];
            pc_q  <= {RESET_PC[31:1], 1'b0};
        end else begin
            off_q <= off_d;
            pc_q  <= pc_d;
        end
    end

endmodule

// File: tb/tb_instr_realigner.sv
// Bench for instr_realigner: directed scenarios plus random traffic against a halfword-stream model.
module tb_instr_realigner;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_is_compressed_o;

    instr_realigner #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_rdata_i         (fetch_rdata_i),
        .fetch_ready_o         (fetch_ready_o),
        .flush_i               (flush_i),
        .flush_addr_i          (flush_addr_i),
        .instr_valid_o         (instr_valid_o),
        .instr_ready_i         (instr_ready_i),
        .instr_o               (instr_o),
        .instr_pc_o            (instr_pc_o),
        .instr_is_compressed_o (instr_is_compressed_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the stream of not-yet-issued halfwords in address order, starting at m_pc.
    logic [15:0] hq[$];
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        m_pc = {RESET_PC[31:1], 1'b0};
    endtask

    task automatic step(input logic fv, input logic [31:0] fd, input logic fl,
                        input logic [31:0] fa, input logic rdy);
        int          words;
        logic        m_ready, m_valid, comp;
        logic [31:0] exp_i;
        @(negedge clk_i);
        fetch_valid_i = fv;
        fetch_rdata_i = fd;
        flush_i       = fl;
        flush_addr_i  = fa;
        instr_ready_i = rdy;
        #1;
        // Words held = halfwords pending plus the skipped lower half when the PC is odd-halfword.
        words   = (hq.size() + int'(m_pc[1]) + 1) / 2;
        m_ready = words < DEPTH;
        comp    = 1'b0;
        if (hq.size() >= 1) comp = (hq[0][1:0] != 2'b11);
        m_valid = !fl && (hq.size() >= 1) && (comp || hq.size() >= 2);
        chk("fetch_ready", {31'd0, fetch_ready_o}, {31'd0, m_ready});
        chk("instr_valid", {31'd0, instr_valid_o}, {31'd0, m_valid});
        chk("instr_pc", instr_pc_o, m_pc);
        if (m_valid) begin
            exp_i = comp ? {16'h0000, hq[0]} : {hq[1], hq[0]};
            chk("instr", instr_o, exp_i);
            chk("is_compressed", {31'd0, instr_is_compressed_o}, {31'd0, comp});
        end
        if (fl) begin
            hq.delete();
            m_pc = {fa[31:1], 1'b0};
        end else begin
            if (m_valid && rdy) begin
                void'(hq.pop_front());
                if (!comp) void'(hq.pop_front());
                m_pc = m_pc + (comp ? 32'd2 : 32'd4);
            end
            if (fv && m_ready) begin
                if (!(hq.size() == 0 && m_pc[1])) hq.push_back(fd[15:0]);
                hq.push_back(fd[31:16]);
            end
        end
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        else if (h[1:0] == 2'b11)      h[1:0] = 2'b01;
        return h;
    endfunction

    initial begin
        rst_i         = 1'b1;
        fetch_valid_i = 1'b0;
        fetch_rdata_i = '0;
        flush_i       = 1'b0;
        flush_addr_i  = '0;
        instr_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_ready", {31'd0, fetch_ready_o}, 32'd1);
        chk("rst_pc", instr_pc_o, RESET_PC);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();

        // Aligned 32b then RVC.
        step(1'b1, 32'h0013_0513, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_4501, 1'b0, 32'h0, 1'b1);
        chk("t1_i0", instr_o, 32'h0013_0513);
        chk("t1_pc0", instr_pc_o, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t1_i1", instr_o, 32'h0000_4501);
        chk("t1_pc1", instr_pc_o, 32'h4);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t1_pc2", instr_pc_o, 32'h6);

        // RVC then a 32b instruction straddling two words.
        step(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h0513_4501, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
        chk("t2_rvc", instr_o, 32'h0000_4501);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t2_straddle", instr_o, 32'h0013_0513);
        chk("t2_pc", instr_pc_o, 32'h2);

        // Flush to an odd halfword: lower half of the first word is skipped.
        step(1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b0);
        step(1'b1, 32'h4505_0517, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t3_instr", instr_o, 32'h0000_4505);
        chk("t3_pc", instr_pc_o, 32'h0000_0102);

        // Backpressure until full, then pop / push+pop.
        step(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h00a0_0093, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0010_0113, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t4_full", {31'd0, fetch_ready_o}, 32'd0);
        step(1'b1, 32'h0020_0193, 1'b0, 32'h0, 1'b1);
        chk("t4_full_pop", instr_o, 32'h00a0_0093);
        step(1'b1, 32'h0020_0193, 1'b0, 32'h0, 1'b1);
        chk("t4_ready_after_pop", {31'd0, fetch_ready_o}, 32'd1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t4_pushpop_ready", {31'd0, fetch_ready_o}, 32'd1);
        chk("t4_pushpop_instr", instr_o, 32'h0020_0193);

        // Flush while full with a word offered.
        step(1'b1, 32'h0030_0213, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0040_0293, 1'b1, 32'h0000_0040, 1'b1);
        chk("t5_full_at_flush", {31'd0, fetch_ready_o}, 32'd0);
        chk("t5_flush_valid", {31'd0, instr_valid_o}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t5_after_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t5_after_ready", {31'd0, fetch_ready_o}, 32'd1);

        // Asynchronous reset while an instruction is offered.
        step(1'b1, 32'h0000_4501, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6_pre_valid", {31'd0, instr_valid_o}, 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t6_async_ready", {31'd0, fetch_ready_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6_pc", instr_pc_o, RESET_PC);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic        fv, fl, rdy;
            logic [31:0] fd, fa;
            fv  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 49) == 0);
            fd  = {rand_half(), rand_half()};
            fa  = {$urandom_range(0, 32'h7fff_ffff), 1'b0};
            step(fv, fd, fl, fa, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
